// File: rtl/cve2v_perf_pkg.sv
// Shared types for the RVFI performance monitor: FSM state encoding, default
// marker instruction and the counter bundle exposed for hierarchical probing.
package cve2v_perf_pkg;

  localparam logic [31:0] FenceInsn = 32'h0ff0000f;

  // Probe struct fields are fixed-width, so CntWidth must not exceed this.
  localparam int unsigned PerfCntMaxWidth = 32;

  localparam int unsigned NumCnt     = 5;
  localparam int unsigned CntCycles  = 0;
  localparam int unsigned CntRetired = 1;
  localparam int unsigned CntLoads   = 2;
  localparam int unsigned CntStores  = 3;
  localparam int unsigned CntTraps   = 4;

  typedef enum logic [1:0] {
    PerfIdle    = 2'd0,
    PerfRunning = 2'd1,
    PerfDrain   = 2'd2,
    PerfDone    = 2'd3
  } perf_state_e;

  typedef struct packed {
    logic [PerfCntMaxWidth-1:0] cycles;
    logic [PerfCntMaxWidth-1:0] retired;
    logic [PerfCntMaxWidth-1:0] loads;
    logic [PerfCntMaxWidth-1:0] stores;
    logic [PerfCntMaxWidth-1:0] traps;
  } perf_cnt_t;

endpackage

// File: rtl/cve2v_rvfi_perf_mon_if.sv
// Retirement (RVFI) signals tapped from cve2v_top; the core side is the master,
// the performance monitor observes through the slave modport.
interface cve2v_rvfi_perf_mon_if;

  logic        valid;
  logic [31:0] insn;
  logic        trap;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;

  modport master (output valid, insn, trap, mem_rmask, mem_wmask);
  modport slave  (input  valid, insn, trap, mem_rmask, mem_wmask);

endinterface

// File: rtl/cve2v_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so an overflowed measurement stays recognisable.
module cve2v_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of evaluation order between always blocks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + Width'(1);
    end
  end

endmodule

// File: rtl/cve2v_rvfi_perf_mon.sv
// Marker-bracketed benchmark monitor on the RVFI port: counts cycles, retired
// instructions, loads, stores and traps, optionally waiting for Spatz to drain.
module cve2v_rvfi_perf_mon
  import cve2v_perf_pkg::*;
#(
  parameter int unsigned CntWidth   = 32,
  parameter logic [31:0] MarkerInsn = FenceInsn,
  parameter bit          VectorMode = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cve2v_rvfi_perf_mon_if.slave  rvfi,
  input  logic                  vec_busy_i,
  input  logic                  clear_i,
  output logic [1:0]            state_o,
  output logic [CntWidth-1:0]   cycles_o,
  output logic [CntWidth-1:0]   retired_o,
  output logic [CntWidth-1:0]   loads_o,
  output logic [CntWidth-1:0]   stores_o,
  output logic [CntWidth-1:0]   traps_o,
  output logic                  done_o,
  output logic                  result_valid_o
);

  perf_state_e         state_q;
  logic                done_q;
  logic                result_valid_q;
  logic                marker_evt;
  logic                cnt_clr;
  logic [NumCnt-1:0]   cnt_inc;
  logic [CntWidth-1:0] cnt_val [NumCnt];
  perf_cnt_t           perf_cnt;

  // NOTE: every signal gets a default at the top of the always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    logic retire_evt;
    marker_evt = rvfi.valid && (rvfi.insn == MarkerInsn) && !rvfi.trap;
    cnt_clr    = clear_i || ((state_q == PerfIdle) && marker_evt);
    // The closing marker ends the region and is deliberately not counted.
    retire_evt = (state_q == PerfRunning) && rvfi.valid && !marker_evt;
    cnt_inc    = '0;
    cnt_inc[CntCycles]  = (state_q == PerfRunning) || (state_q == PerfDrain);
    cnt_inc[CntRetired] = retire_evt && !rvfi.trap;
    cnt_inc[CntLoads]   = retire_evt && !rvfi.trap && (rvfi.mem_rmask != 4'h0);
    cnt_inc[CntStores]  = retire_evt && !rvfi.trap && (rvfi.mem_wmask != 4'h0);
    cnt_inc[CntTraps]   = retire_evt && rvfi.trap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= PerfIdle;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else if (clear_i) begin
      state_q        <= PerfIdle;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PerfIdle: begin
          if (marker_evt) begin
            state_q        <= PerfRunning;
            result_valid_q <= 1'b0;
          end
        end
        PerfRunning: begin
          if (marker_evt) begin
            if (VectorMode) begin
              state_q <= PerfDrain;
            end else begin
              state_q        <= PerfDone;
              done_q         <= 1'b1;
              result_valid_q <= 1'b1;
            end
          end
        end
        PerfDrain: begin
          if (!vec_busy_i) begin
            state_q        <= PerfDone;
            done_q         <= 1'b1;
            result_valid_q <= 1'b1;
          end
        end
        default: state_q <= PerfIdle;
      endcase
    end
  end

  for (genvar i = 0; i < NumCnt; i++) begin : g_cnt
    cve2v_sat_counter #(
      .Width (CntWidth)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc[i]),
      .cnt_o  (cnt_val[i])
    );
  end

  assign perf_cnt = '{
    cycles:  PerfCntMaxWidth'(cnt_val[CntCycles]),
    retired: PerfCntMaxWidth'(cnt_val[CntRetired]),
    loads:   PerfCntMaxWidth'(cnt_val[CntLoads]),
    stores:  PerfCntMaxWidth'(cnt_val[CntStores]),
    traps:   PerfCntMaxWidth'(cnt_val[CntTraps])
  };

  assign state_o        = state_q;
  assign cycles_o       = perf_cnt.cycles[CntWidth-1:0];
  assign retired_o      = perf_cnt.retired[CntWidth-1:0];
  assign loads_o        = perf_cnt.loads[CntWidth-1:0];
  assign stores_o       = perf_cnt.stores[CntWidth-1:0];
  assign traps_o        = perf_cnt.traps[CntWidth-1:0];
  assign done_o         = done_q;
  assign result_valid_o = result_valid_q;

endmodule

// File: tb/tb_cve2v_rvfi_perf_mon.sv
// Scoreboard bench: three monitors (scalar, vector, 4-bit saturating) share one
// RVFI stream; region outcomes are predicted from the timing rules and checked on done.
module tb_cve2v_rvfi_perf_mon;

  localparam int          NumDut  = 3;
  localparam logic [31:0] Marker  = 32'h0ff0000f;
  localparam logic [31:0] AluInsn = 32'h00000013;
  localparam logic [31:0] SIdle = 0, SRun = 1, SDrain = 2, SDone = 3;

  typedef struct packed {
    logic [31:0]      done_cyc;
    logic [4:0][31:0] c;  // [0] cycles, [1] retired, [2] loads, [3] stores, [4] traps
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic vec_busy;
  logic clear;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  cve2v_rvfi_perf_mon_if rvfi_if ();

  logic [1:0]  st0, st1, st2;
  logic        dn0, dn1, dn2, rv0, rv1, rv2;
  logic [31:0] cy0, re0, lo0, so0, tr0, cy1, re1, lo1, so1, tr1;
  logic [3:0]  cy2, re2, lo2, so2, tr2;

  cve2v_rvfi_perf_mon #(.CntWidth(32), .VectorMode(1'b0)) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rvfi(rvfi_if), .vec_busy_i(vec_busy), .clear_i(clear),
    .state_o(st0), .cycles_o(cy0), .retired_o(re0), .loads_o(lo0), .stores_o(so0),
    .traps_o(tr0), .done_o(dn0), .result_valid_o(rv0));

  cve2v_rvfi_perf_mon #(.CntWidth(32), .VectorMode(1'b1)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rvfi(rvfi_if), .vec_busy_i(vec_busy), .clear_i(clear),
    .state_o(st1), .cycles_o(cy1), .retired_o(re1), .loads_o(lo1), .stores_o(so1),
    .traps_o(tr1), .done_o(dn1), .result_valid_o(rv1));

  cve2v_rvfi_perf_mon #(.CntWidth(4), .VectorMode(1'b0)) u_dut2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .rvfi(rvfi_if), .vec_busy_i(vec_busy), .clear_i(clear),
    .state_o(st2), .cycles_o(cy2), .retired_o(re2), .loads_o(lo2), .stores_o(so2),
    .traps_o(tr2), .done_o(dn2), .result_valid_o(rv2));

  logic [1:0]       o_st  [NumDut];
  logic             o_dn  [NumDut];
  logic             o_rv  [NumDut];
  logic [4:0][31:0] o_cnt [NumDut];

  always_comb begin
    o_st[0] = st0; o_st[1] = st1; o_st[2] = st2;
    o_dn[0] = dn0; o_dn[1] = dn1; o_dn[2] = dn2;
    o_rv[0] = rv0; o_rv[1] = rv1; o_rv[2] = rv2;
    o_cnt[0] = {tr0, so0, lo0, re0, cy0};
    o_cnt[1] = {tr1, so1, lo1, re1, cy1};
    o_cnt[2] = {28'd0, tr2, 28'd0, so2, 28'd0, lo2, 28'd0, re2, 28'd0, cy2};
  end

  exp_t sbq [NumDut][$];
  bit   rv_pend [NumDut];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic string cnt_name(input int i);
    case (i)
      0:       return "cycles";
      1:       return "retired";
      2:       return "loads";
      3:       return "stores";
      default: return "traps";
    endcase
  endfunction

  function automatic logic [31:0] sat4(input logic [31:0] x);
    return (x > 32'd15) ? 32'd15 : x;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] x;
    x = $urandom;
    if (x == Marker) x = x ^ 32'h1;
    return x;
  endfunction

  // Monitor: pops one prediction per done pulse, then expects result_valid next cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni) begin
      for (int k = 0; k < NumDut; k++) begin
        if (rv_pend[k]) begin
          check($sformatf("dut%0d result_valid after done", k), 32'(o_rv[k]), 32'd1);
          rv_pend[k] = 1'b0;
        end
        if (o_dn[k]) begin
          if (sbq[k].size() == 0) begin
            check($sformatf("dut%0d spurious done", k), 32'(o_dn[k]), 32'd0);
          end else begin
            e = sbq[k].pop_front();
            check($sformatf("dut%0d done cycle", k), 32'(cyc), e.done_cyc);
            for (int i = 0; i < 5; i++)
              check($sformatf("dut%0d %s", k, cnt_name(i)), o_cnt[k][i], e.c[i]);
            rv_pend[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_rvfi(input bit v, input logic [31:0] insn, input bit trap,
                          input logic [3:0] rm, input logic [3:0] wm);
    rvfi_if.valid     = v;
    rvfi_if.insn      = insn;
    rvfi_if.trap      = trap;
    rvfi_if.mem_rmask = rm;
    rvfi_if.mem_wmask = wm;
  endtask

  task automatic check_idle_all(input string tag);
    for (int k = 0; k < NumDut; k++) begin
      check($sformatf("dut%0d %s state", k, tag), 32'(o_st[k]), SIdle);
      check($sformatf("dut%0d %s done", k, tag), 32'(o_dn[k]), 32'd0);
      check($sformatf("dut%0d %s result_valid", k, tag), 32'(o_rv[k]), 32'd0);
      for (int i = 0; i < 5; i++)
        check($sformatf("dut%0d %s %s", k, tag, cnt_name(i)), o_cnt[k][i], 32'd0);
    end
  endtask

  // kind 0: random body, 1: 20 ALU + 3 loads + 2 stores, 2: trapped markers/loads mix.
  task automatic region(input int kind, input int body_len, input int busy_len);
    int   t, u, d, r;
    int   n_ret, n_ld, n_st, n_tp;
    exp_t e;
    n_ret = 0; n_ld = 0; n_st = 0; n_tp = 0;
    t = cyc;
    set_rvfi(1'b1, Marker, 1'b0, 4'h0, 4'h0);
    vec_busy = 1'($urandom);
    tick();
    for (int k = 0; k < NumDut; k++) begin
      check($sformatf("dut%0d state after start", k), 32'(o_st[k]), SRun);
      check($sformatf("dut%0d result_valid after start", k), 32'(o_rv[k]), 32'd0);
    end
    for (int i = 0; i < body_len; i++) begin
      case (kind)
        1: begin
          if (i < 25)
            set_rvfi(1'b1, AluInsn, 1'b0, (i >= 20 && i < 23) ? 4'hf : 4'h0,
                     (i >= 23) ? 4'h3 : 4'h0);
          else
            set_rvfi(1'b0, Marker, 1'b0, 4'h0, 4'h0);
        end
        2: begin
          case (i % 4)
            0:       set_rvfi(1'b1, Marker, 1'b1, 4'h0, 4'h0);
            1:       set_rvfi(1'b1, rand_insn(), 1'b1, 4'hf, 4'h0);
            2:       set_rvfi(1'b1, AluInsn, 1'b0, 4'h0, 4'h0);
            default: set_rvfi(1'b0, Marker, 1'b0, 4'h0, 4'h0);
          endcase
        end
        default: begin
          r = $urandom_range(0, 9);
          if (r < 2)
            set_rvfi(1'b0, (r == 0) ? Marker : rand_insn(), 1'b0, 4'($urandom), 4'($urandom));
          else if (r == 2)
            set_rvfi(1'b1, Marker, 1'b1, 4'h0, 4'h0);
          else if (r == 3)
            set_rvfi(1'b1, rand_insn(), 1'b1, 4'($urandom), 4'($urandom));
          else
            set_rvfi(1'b1, rand_insn(), 1'b0,
                     ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                     ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
        end
      endcase
      vec_busy = 1'($urandom);
      if (rvfi_if.valid) begin
        if (rvfi_if.trap) n_tp++;
        else begin
          n_ret++;
          if (rvfi_if.mem_rmask != 4'h0) n_ld++;
          if (rvfi_if.mem_wmask != 4'h0) n_st++;
        end
      end
      tick();
    end
    u = cyc;
    d = u + 1 + busy_len;
    set_rvfi(1'b1, Marker, 1'b0, 4'h0, 4'h0);
    e.c = {32'(n_tp), 32'(n_st), 32'(n_ld), 32'(n_ret), 32'(u - t)};
    e.done_cyc = 32'(u + 1);
    sbq[0].push_back(e);
    e.c[0] = 32'(d - t);
    e.done_cyc = 32'(d + 1);
    sbq[1].push_back(e);
    e.c[0] = 32'(u - t);
    e.done_cyc = 32'(u + 1);
    for (int i = 0; i < 5; i++) e.c[i] = sat4(e.c[i]);
    sbq[2].push_back(e);
    tick();
    check("dut0 state after close", 32'(o_st[0]), SDone);
    check("dut1 state after close", 32'(o_st[1]), SDrain);
    check("dut2 state after close", 32'(o_st[2]), SDone);
    // A marker in DONE/DRAIN must not restart; later traffic must be ignored.
    for (int i = 0; cyc <= d + 2; i++) begin
      if (i == 0) set_rvfi(1'b1, Marker, 1'b0, 4'h0, 4'h0);
      else set_rvfi(1'($urandom), rand_insn(), 1'($urandom), 4'($urandom), 4'($urandom));
      vec_busy = (i < busy_len);
      tick();
    end
    set_rvfi(1'b0, 32'h0, 1'b0, 4'h0, 4'h0);
    vec_busy = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    clear = 1'b0;
    vec_busy = 1'b0;
    set_rvfi(1'b0, 32'h0, 1'b0, 4'h0, 4'h0);
    tick();
    tick();
    check_idle_all("reset");
    rst_ni = 1'b1;
    while (cyc < 10) tick();

    region(1, 39, 0);   // markers at t and t+40: 40 cycles, 25 retired, 3 loads, 2 stores
    region(2, 19, 13);  // markers 20 apart, busy 13 cycles: vector cycles 34
    for (int n = 0; n < 6; n++) region(0, $urandom_range(3, 40), $urandom_range(0, 6));

    // Clear coinciding with the closing marker wins: no done pulse, everything zero.
    set_rvfi(1'b1, Marker, 1'b0, 4'h0, 4'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_rvfi(1'b1, AluInsn, 1'b0, 4'h1, 4'h0);
      tick();
    end
    set_rvfi(1'b1, Marker, 1'b0, 4'h0, 4'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_rvfi(1'b0, 32'h0, 1'b0, 4'h0, 4'h0);
    check_idle_all("clear");
    for (int i = 0; i < 4; i++) tick();

    // Reset dropped mid-region must clear outputs without waiting for a clock edge.
    set_rvfi(1'b1, Marker, 1'b0, 4'h0, 4'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_rvfi(1'b1, AluInsn, 1'b0, 4'h0, 4'hf);
      tick();
    end
    set_rvfi(1'b0, 32'h0, 1'b0, 4'h0, 4'h0);
    #2 rst_ni = 1'b0;
    #1 check_idle_all("async reset");
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    region(0, 12, 3);
    region(1, 39, 2);

    for (int k = 0; k < NumDut; k++)
      check($sformatf("dut%0d outstanding predicted results", k), 32'(sbq[k].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
